// File: rtl/zvc_compressor.sv
// Zero-value compressor: packs the non-zero words of one LIFM line (and their
// MT entries) into the lowest output slots, stable order, one-cycle latency.
module zvc_compressor #(
    parameter int unsigned WORD_WIDTH    = 8,
    parameter int unsigned LINE_SIZE     = 128,
    parameter int unsigned DIST_WIDTH    = 7,
    parameter int unsigned MAX_LIFM_RSIZ = 4
) (
    input  logic                                         clk,
    input  logic                                         reset_n,
    input  logic [LINE_SIZE*WORD_WIDTH-1:0]              lifm_line,
    input  logic [LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ-1:0] mt_line,
    output logic [LINE_SIZE*WORD_WIDTH-1:0]              lifm_comp,
    output logic [LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ-1:0] mt_comp
);

    localparam int unsigned ME = DIST_WIDTH * MAX_LIFM_RSIZ;
    localparam int unsigned LW = LINE_SIZE * WORD_WIDTH;
    localparam int unsigned MW = LINE_SIZE * ME;

    logic [LW-1:0] lifm_comp_d, lifm_comp_q;
    logic [MW-1:0] mt_comp_d, mt_comp_q;

    // Running exclusive prefix count of non-zero words selects each word's slot.
    always_comb begin
        int unsigned cnt;
        lifm_comp_d = '0;
        mt_comp_d   = '0;
        cnt         = 0;
        for (int unsigned i = 0; i < LINE_SIZE; i++) begin
            if (lifm_line[i*WORD_WIDTH +: WORD_WIDTH] != '0) begin
                lifm_comp_d[cnt*WORD_WIDTH +: WORD_WIDTH] = lifm_line[i*WORD_WIDTH +: WORD_WIDTH];
                mt_comp_d[cnt*ME +: ME]                   = mt_line[i*ME +: ME];
                cnt                                       = cnt + 1;
            end
        end
    end

    // The reset level is high despite the port name; reset wins over capture.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            lifm_comp_q <= '0;
            mt_comp_q   <= '0;
        end else begin
            lifm_comp_q <= lifm_comp_d;
            mt_comp_q   <= mt_comp_d;
        end
    end

    assign lifm_comp = lifm_comp_q;
    assign mt_comp   = mt_comp_q;

endmodule

// File: tb/tb_zvc_compressor.sv
// Self-checking bench for zvc_compressor: scoreboard of gathered reference lines
// plus directed slot checks for the sparse, dense, alternating and reset cases.
module tb_zvc_compressor;

    localparam int unsigned WW = 8;
    localparam int unsigned LS = 128;
    localparam int unsigned DW = 7;
    localparam int unsigned RS = 4;
    localparam int unsigned ME = DW * RS;
    localparam int unsigned LW = LS * WW;
    localparam int unsigned MW = LS * ME;

    typedef struct packed {
        logic [LW-1:0] lf;
        logic [MW-1:0] mt;
    } exp_t;

    logic          clk;
    logic          reset_n;
    logic [LW-1:0] lifm_line;
    logic [MW-1:0] mt_line;
    logic [LW-1:0] lifm_comp;
    logic [MW-1:0] mt_comp;

    int   checks;
    int   errors;
    exp_t sb[$];

    zvc_compressor #(
        .WORD_WIDTH   (WW),
        .LINE_SIZE    (LS),
        .DIST_WIDTH   (DW),
        .MAX_LIFM_RSIZ(RS)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .lifm_line(lifm_line),
        .mt_line  (mt_line),
        .lifm_comp(lifm_comp),
        .mt_comp  (mt_comp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // Reference: for each output slot k, gather the k-th non-zero input word.
    function automatic exp_t model(input logic [LW-1:0] l, input logic [MW-1:0] m);
        exp_t r;
        int   seen;
        r = '0;
        for (int k = 0; k < int'(LS); k++) begin
            seen = 0;
            for (int i = 0; i < int'(LS); i++) begin
                if (l[i*WW +: WW] != '0) begin
                    if (seen == k) begin
                        r.lf[k*WW +: WW] = l[i*WW +: WW];
                        r.mt[k*ME +: ME] = m[i*ME +: ME];
                    end
                    seen++;
                end
            end
        end
        return r;
    endfunction

    task automatic chk_lifm(input string tag, input logic [LW-1:0] g, input logic [LW-1:0] e);
        int s;
        s = 0;
        checks++;
        assert (g === e) else begin
            errors++;
            for (int k = int'(LS) - 1; k >= 0; k--) if (g[k*WW +: WW] !== e[k*WW +: WW]) s = k;
            $error("FAIL %s lifm slot %0d got=%h exp=%h", tag, s, g[s*WW +: WW], e[s*WW +: WW]);
        end
    endtask

    task automatic chk_mt(input string tag, input logic [MW-1:0] g, input logic [MW-1:0] e);
        int s;
        s = 0;
        checks++;
        assert (g === e) else begin
            errors++;
            for (int k = int'(LS) - 1; k >= 0; k--) if (g[k*ME +: ME] !== e[k*ME +: ME]) s = k;
            $error("FAIL %s mt slot %0d got=%h exp=%h", tag, s, g[s*ME +: ME], e[s*ME +: ME]);
        end
    endtask

    task automatic chk_val(input string tag, input logic [31:0] g, input logic [31:0] e);
        checks++;
        assert (g === e) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, g, e);
        end
    endtask

    // One clock: drive at negedge, push expectation, compare #1 after posedge.
    task automatic step(input string tag, input logic rst, input logic [LW-1:0] l, input logic [MW-1:0] m);
        exp_t e;
        @(negedge clk);
        reset_n   = rst;
        lifm_line = l;
        mt_line   = m;
        sb.push_back(rst ? exp_t'('0) : model(l, m));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk_lifm(tag, lifm_comp, e.lf);
        chk_mt(tag, mt_comp, e.mt);
    endtask

    logic [LW-1:0] l;
    logic [MW-1:0] m, m_idx;

    initial begin
        checks    = 0;
        errors    = 0;
        reset_n   = 1'b1;
        lifm_line = '0;
        mt_line   = '0;
        for (int i = 0; i < int'(LS); i++) m_idx[i*ME +: ME] = ME'(i);

        // Reset state with a non-zero line applied.
        l = '0; l[5*WW +: WW] = 8'h11;
        step("reset_init", 1'b1, l, m_idx);
        chk_lifm("reset_zero_lifm", lifm_comp, '0);
        chk_mt("reset_zero_mt", mt_comp, '0);

        // Sparse line.
        l = '0;
        l[3*WW +: WW] = 8'd13; l[8*WW +: WW] = 8'd47; l[15*WW +: WW] = 8'd22;
        step("sparse", 1'b0, l, m_idx);
        chk_val("sparse_w0", 32'(lifm_comp[0*WW +: WW]), 32'd13);
        chk_val("sparse_w1", 32'(lifm_comp[1*WW +: WW]), 32'd47);
        chk_val("sparse_w2", 32'(lifm_comp[2*WW +: WW]), 32'd22);
        chk_val("sparse_m0", 32'(mt_comp[0*ME +: ME]), 32'd3);
        chk_val("sparse_m1", 32'(mt_comp[1*ME +: ME]), 32'd8);
        chk_val("sparse_m2", 32'(mt_comp[2*ME +: ME]), 32'd15);
        chk_val("sparse_rest", 32'(lifm_comp[LW-1:3*WW] != '0 || mt_comp[MW-1:3*ME] != '0), 32'd0);

        // All-zero line with non-zero MT.
        for (int i = 0; i < int'(LS); i++) m[i*ME +: ME] = ME'($urandom) | ME'(1);
        step("all_zero", 1'b0, '0, m);
        chk_lifm("all_zero_lifm", lifm_comp, '0);
        chk_mt("all_zero_mt", mt_comp, '0);

        // Dense line: outputs must equal the inputs.
        for (int i = 0; i < int'(LS); i++) begin
            l[i*WW +: WW] = WW'(i + 1);
            m[i*ME +: ME] = ME'($urandom);
        end
        step("dense", 1'b0, l, m);
        chk_lifm("dense_eq_lifm", lifm_comp, l);
        chk_mt("dense_eq_mt", mt_comp, m);

        // Alternating line: odd indices 0xFF.
        for (int i = 0; i < int'(LS); i++) l[i*WW +: WW] = (i % 2 == 1) ? 8'hFF : 8'h00;
        step("alternate", 1'b0, l, m_idx);
        for (int k = 0; k < int'(LS); k++) begin
            chk_val("alt_w", 32'(lifm_comp[k*WW +: WW]), (k < 64) ? 32'hFF : 32'h0);
            chk_val("alt_m", 32'(mt_comp[k*ME +: ME]), (k < 64) ? 32'(2 * k + 1) : 32'h0);
        end

        // Back-to-back random lines, one per edge.
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < int'(LS); i++) begin
                l[i*WW +: WW] = ($urandom_range(0, 2) == 0) ? WW'($urandom) : '0;
                m[i*ME +: ME] = ME'($urandom);
            end
            step("b2b", 1'b0, l, m);
        end

        // Mid-stream reset drops the line presented at the reset edge.
        l = '0; l[100*WW +: WW] = 8'h5A; l[127*WW +: WW] = 8'h01; l[0] = 1'b1;
        step("mid_reset", 1'b1, l, m_idx);
        chk_lifm("mid_reset_lifm", lifm_comp, '0);
        step("post_reset", 1'b0, l, m_idx);
        chk_val("post_reset_w0", 32'(lifm_comp[0*WW +: WW]), 32'h01);
        chk_val("post_reset_w1", 32'(lifm_comp[1*WW +: WW]), 32'h5A);
        chk_val("post_reset_w2", 32'(lifm_comp[2*WW +: WW]), 32'h01);
        chk_val("post_reset_m2", 32'(mt_comp[2*ME +: ME]), 32'd127);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/zvc_compressor.md
# zvc_compressor

Zero-value compressor for one input-feature-map (LIFM) line. Each cycle it removes all zero-valued words from a line of `LINE_SIZE` words and packs the non-zero words, in original order, into the lowest output slots. Each word's mapping-table (MT) entry travels with it. The block sits between the line buffer and the redundancy-controller datapath, which consumes only compressed lines.

## Interface
Parameters:
- `WORD_WIDTH`, default 8: bits per LIFM word.
- `LINE_SIZE`, default 128: words per line.
- `DIST_WIDTH`, default 7: bits per MT distance field.
- `MAX_LIFM_RSIZ`, default 4: distance fields per word; MT entry width `ME = DIST_WIDTH*MAX_LIFM_RSIZ`.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset_n`, input, 1: reset, synchronous and active-high. Despite the name, the value 1 resets.
- `lifm_line`, input, `LINE_SIZE*WORD_WIDTH`: uncompressed line; word i is at `[i*WORD_WIDTH +: WORD_WIDTH]`.
- `mt_line`, input, `LINE_SIZE*ME`: MT entries; entry i is at `[i*ME +: ME]` and belongs to word i.
- `lifm_comp`, output, `LINE_SIZE*WORD_WIDTH`: compressed line, same slot layout as the input.
- `mt_comp`, output, `LINE_SIZE*ME`: compressed MT, same slot layout as the input.

## Operation
- A word is zero iff all `WORD_WIDTH` bits are 0. MT content never affects classification.
- For each input index i with a non-zero word, compute its destination `k` = number of non-zero words at indices `0..i-1` (exclusive prefix count, width `clog2(LINE_SIZE)+1`).
- Output slot k gets the word i value and the MT entry i, both copied unchanged.
- Relative order of non-zero words is preserved; the packing is stable.
- Slots `k >= N` (N = total non-zero count) are driven to all-zero in both `lifm_comp` and `mt_comp`.
- MT entries of zero words are discarded.
- All-zero line: both outputs are all-zero.
- No zero words (N = `LINE_SIZE`): the outputs equal the inputs.
- Implementation is free: prefix-sum plus per-output-slot select, or a log-depth compaction network. It must be purely combinational up to the output register and complete within one cycle.

## Timing
- Outputs are registered, with one cycle of latency. The input sampled at rising edge t appears on the outputs after edge t and holds until edge t+1.
- A new line is accepted every cycle. There is no valid/ready handshake; the block is always capturing.
- Reset: on a rising edge with `reset_n`=1, both outputs become all-zero. Reset takes priority over the capture of that edge's input.
- Reset mid-stream: the line presented at the reset edge is dropped. The first edge with `reset_n`=0 captures normally.
- Output values before the first edge (with no reset yet) are unspecified.
- Inputs with X/Z bits: no requirement. Benches must drive defined values.

## Test plan
- **Sparse line:** words 3=13, 8=47, 15=22, all others 0, MT entry i = i. One edge later, `lifm_comp` slots 0/1/2 must equal 13/47/22 and `mt_comp` slots 0/1/2 must equal 3/8/15. All other slots must be 0.
- **All-zero line:** `lifm_line`=0 with arbitrary non-zero MT. Both outputs must be all-zero.
- **Dense line:** word i = i+1 (mod 256, with word 255 skipped by using i=0..127 → 1..128), MT random. Outputs must equal the inputs exactly.
- **Alternating line:** odd indices = 0xFF, even indices = 0, MT entry i = i. Slot k (k < 64) must hold 0xFF with MT = 2k+1. Slots 64..127 must be 0.
- **Back-to-back lines:** a different line on each of 3 consecutive edges. Each output must reflect the line captured on the immediately preceding edge, with no bubbles.
- **Reset:** assert `reset_n`=1 for one edge while a non-zero line is applied. Outputs must be 0 after that edge. After deassertion, the next edge must produce the compressed form of the applied line.
